// File: rtl/frame_hit_bcd_hex_if.sv
// Signal bundle for the frame hit / BCD display helper: scan coordinates and value in,
// region flags, BCD digits and 7-segment codes out.
interface frame_hit_bcd_hex_if;
    logic [10:0] X_POS;
    logic [10:0] Y_POS;
    logic [10:0] X_CONTROLLO;
    logic [10:0] Y_CONTROLLO;
    logic [19:0] binary;
    logic        CONFERMA;
    logic        interno;
    logic        ovf;
    logic [3:0]  D5, D4, D3, D2, D1, D0;
    logic [6:0]  HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

    modport master (
        output X_POS, Y_POS, X_CONTROLLO, Y_CONTROLLO, binary,
        input  CONFERMA, interno, ovf,
        input  D5, D4, D3, D2, D1, D0,
        input  HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
    );

    modport slave (
        input  X_POS, Y_POS, X_CONTROLLO, Y_CONTROLLO, binary,
        output CONFERMA, interno, ovf,
        output D5, D4, D3, D2, D1, D0,
        output HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
    );
endinterface

// File: rtl/frame_hit_bcd_hex.sv
// Per-pixel frame/interior hit test plus 20-bit binary to 6-digit BCD and 7-segment drive.
// Every output is registered on VGA_CLK; reset is asynchronous and active-low.
module frame_hit_bcd_hex #(
    parameter int unsigned ALTEZZA   = 300,
    parameter int unsigned LARGHEZZA = 400,
    parameter int unsigned SPESSORE  = 20
) (
    input  logic                 VGA_CLK,
    input  logic                 reset,
    frame_hit_bcd_hex_if.slave   bus
);

    localparam logic [11:0] Alt  = 12'(ALTEZZA);
    localparam logic [11:0] Larg = 12'(LARGHEZZA);
    localparam logic [11:0] Spes = 12'(SPESSORE);
    localparam bit InnerOk = (2 * SPESSORE < LARGHEZZA) && (2 * SPESSORE < ALTEZZA);
    localparam logic [6:0] SegBlank = 7'h7F;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // Geometry, widened to 12 bits so rectangles past 2047 clip instead of wrapping.
    logic [11:0] x, y, x_lo, y_lo, x_hi, y_hi;
    logic [11:0] xi_lo, yi_lo, xi_hi, yi_hi;
    logic        outer, inner;
    logic        conferma_d, conferma_q;
    logic        interno_d, interno_q;

    always_comb begin
        x     = {1'b0, bus.X_CONTROLLO};
        y     = {1'b0, bus.Y_CONTROLLO};
        x_lo  = {1'b0, bus.X_POS};
        y_lo  = {1'b0, bus.Y_POS};
        x_hi  = x_lo + Larg;
        y_hi  = y_lo + Alt;
        xi_lo = x_lo + Spes;
        yi_lo = y_lo + Spes;
        xi_hi = x_hi - Spes;
        yi_hi = y_hi - Spes;
        outer = (x >= x_lo) && (x < x_hi) && (y >= y_lo) && (y < y_hi);
        inner = InnerOk && (x >= xi_lo) && (x < xi_hi) && (y >= yi_lo) && (y < yi_hi);
        conferma_d = outer && !inner;
        interno_d  = inner;
    end

    // Double-dabble, MSB first; any carry out of the top digit only matters on overflow,
    // where the digits are forced to all nines anyway.
    logic [23:0] bcd;
    logic        ovf_d, ovf_q;
    logic [23:0] digits_d, digits_q;
    logic [41:0] hex_d, hex_q;

    always_comb begin
        bcd = '0;
        for (int i = 19; i >= 0; i--) begin
            for (int d = 0; d < 6; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[22:0], bus.binary[i]};
        end
        ovf_d    = (bus.binary > 20'd999999);
        digits_d = ovf_d ? 24'h999999 : bcd;
        hex_d    = '0;
        for (int d = 0; d < 6; d++) begin
            hex_d[7*d +: 7] = seg7(digits_d[4*d +: 4]);
        end
    end

    always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
            conferma_q <= 1'b0;
            interno_q  <= 1'b0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
            hex_q      <= {6{SegBlank}};
        end else begin
            conferma_q <= conferma_d;
            interno_q  <= interno_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
            hex_q      <= hex_d;
        end
    end

    assign bus.CONFERMA = conferma_q;
    assign bus.interno  = interno_q;
    assign bus.ovf      = ovf_q;
    assign {bus.D5, bus.D4, bus.D3, bus.D2, bus.D1, bus.D0} = digits_q;
    assign {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} = hex_q;

endmodule

// File: tb/tb_frame_hit_bcd_hex.sv
// Directed bench for frame_hit_bcd_hex: reset, frame/interior hits, border edges,
// clipping, BCD conversion, saturation and segment codes.
module tb_frame_hit_bcd_hex;

    logic VGA_CLK = 1'b0;
    logic reset   = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    frame_hit_bcd_hex_if bus ();

    frame_hit_bcd_hex dut (
        .VGA_CLK (VGA_CLK),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        bus.X_CONTROLLO = 11'(x);
        bus.Y_CONTROLLO = 11'(y);
    endtask

    task automatic chk_reg(input string tag, input logic c, input logic i);
        chk({tag, " CONFERMA"}, 48'(bus.CONFERMA), 48'(c));
        chk({tag, " interno"},  48'(bus.interno),  48'(i));
    endtask

    task automatic chk_num(input string tag, input logic [23:0] dig, input logic [41:0] hex,
                           input logic ovf);
        chk({tag, " D"},   48'({bus.D5, bus.D4, bus.D3, bus.D2, bus.D1, bus.D0}), 48'(dig));
        chk({tag, " HEX"}, 48'({bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}),
            48'(hex));
        chk({tag, " ovf"}, 48'(bus.ovf), 48'(ovf));
    endtask

    localparam logic [41:0] HexBlank = {6{7'h7F}};
    localparam logic [41:0] HexNines = {6{7'h10}};
    localparam logic [41:0] HexZeros = {6{7'h40}};

    initial begin
        bus.X_POS = 11'd440;
        bus.Y_POS = 11'd362;
        pix(440, 362);
        bus.binary = 20'd1023;

        // Reset held low while clock and inputs toggle.
        for (int k = 0; k < 4; k++) begin
            bus.X_CONTROLLO = 11'($urandom_range(0, 2047));
            bus.Y_CONTROLLO = 11'($urandom_range(0, 2047));
            bus.binary      = 20'($urandom);
            step();
            chk_reg("reset", 1'b0, 1'b0);
            chk_num("reset", 24'h0, HexBlank, 1'b0);
        end

        bus.X_POS  = 11'd440;
        bus.Y_POS  = 11'd362;
        bus.binary = 20'd1023;
        pix(440, 362);
        #2 reset = 1'b1;
        step();
        chk_reg("corner 440,362", 1'b1, 1'b0);
        chk_num("bin 1023", 24'h001023,
                {7'h40, 7'h40, 7'h79, 7'h40, 7'h24, 7'h30}, 1'b0);

        // One-cycle latency: output holds until the next edge.
        pix(460, 382);
        #2;
        chk_reg("latency hold", 1'b1, 1'b0);
        step();
        chk_reg("inner 460,382", 1'b0, 1'b1);

        pix(839, 661); step(); chk_reg("corner 839,661", 1'b1, 1'b0);
        pix(839, 761); step(); chk_reg("below 839,761", 1'b0, 1'b0);
        pix(840, 362); step(); chk_reg("right 840,362", 1'b0, 1'b0);
        pix(439, 500); step(); chk_reg("left 439,500", 1'b0, 1'b0);
        pix(459, 500); step(); chk_reg("edge 459,500", 1'b1, 1'b0);
        pix(460, 500); step(); chk_reg("edge 460,500", 1'b0, 1'b1);
        pix(819, 500); step(); chk_reg("edge 819,500", 1'b0, 1'b1);
        pix(820, 500); step(); chk_reg("edge 820,500", 1'b1, 1'b0);
        pix(600, 641); step(); chk_reg("edge 600,641", 1'b0, 1'b1);
        pix(600, 642); step(); chk_reg("edge 600,642", 1'b1, 1'b0);

        // Clipping near the right edge of the coordinate space.
        bus.X_POS = 11'd1900;
        pix(2040, 500); step(); chk_reg("clip 2040", 1'b0, 1'b1);
        pix(5, 500);    step(); chk_reg("clip 5", 1'b0, 1'b0);
        pix(1910, 500); step(); chk_reg("clip 1910", 1'b1, 1'b0);

        bus.binary = 20'd999999;  step(); chk_num("bin 999999", 24'h999999, HexNines, 1'b0);
        bus.binary = 20'd1048575; step(); chk_num("bin max", 24'h999999, HexNines, 1'b1);
        bus.binary = 20'd1000000; step(); chk_num("bin 1e6", 24'h999999, HexNines, 1'b1);
        bus.binary = 20'd0;       step(); chk_num("bin 0", 24'h000000, HexZeros, 1'b0);
        bus.binary = 20'd456789;  step();
        chk_num("bin 456789", 24'h456789,
                {7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10}, 1'b0);
        bus.binary = 20'd123;     step();
        chk_num("bin 123", 24'h000123,
                {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30}, 1'b0);

        // Asynchronous reset between edges.
        pix(2040, 500);
        step();
        chk_reg("pre async", 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk_reg("async reset", 1'b0, 1'b0);
        chk_num("async reset", 24'h0, HexBlank, 1'b0);
        step();
        chk_reg("async hold", 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk_reg("after release", 1'b0, 1'b1);
        chk_num("after release", 24'h000123,
                {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30}, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
